serial_subtractor: RTL and testbench

- Bit-serial, LSB-first subtractor: computes a - b over WIDTH cycles using a single full-subtractor cell and a borrow flip-flop.
- Arithmetic inverse of the combinational full adder; companion to the ripple adders in the ALU path.
- Used where area matters more than latency.
- Start/busy/done handshake; the result is held until the next operation.

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) using one full-subtractor cell and a borrow flop.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to add an op input (1 = subtract, 0 = add).
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic a0;
  logic b0;
  logic d;
  logic next_br;
  logic sub_mode;
  logic ovf_next;

  assign fsm_state = state;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic op_q;
  assign sub_mode = op_q;
`else
  assign sub_mode = 1'b1;
`endif

  // One cell: the sum/difference bit is identical; only the borrow/carry term differs.
  assign a0      = sa[0];
  assign b0      = sb[0];
  assign d       = a0 ^ b0 ^ br;
  assign next_br = sub_mode ? ((~a0 & b0) | (~(a0 ^ b0) & br))
                            : ((a0 & b0) | ((a0 ^ b0) & br));
  // On the final step d is the result MSB.
  assign ovf_next = (sub_mode ? (a_msb != b_msb) : (a_msb == b_msb)) && (d != a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q  <= 1'b1;
`endif
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            op_q  <= op;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res <= {d, res[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          br  <= next_br;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= {d, res[WIDTH-1:1]};
            bout  <= next_br;
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 with hand-computed expected results.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic [1:0] fsm_state;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic       op;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_diff = 8'h00;
  logic       prev_bout = 1'b0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op        (op),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then follow the run to its done pulse.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    n = 0;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    check({tag, " busy_first"}, busy, 1);
    while (!done && n < 20) begin
      n++;
      if (n == 4) begin
        check({tag, " diff_hold"}, diff, prev_diff);
        check({tag, " bout_hold"}, bout, prev_bout);
      end
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, 8);
    check({tag, " done"}, done, 1);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " diff"}, diff, ed);
    check({tag, " bout"}, bout, eb);
    check({tag, " ovf"}, ovf, eo);
    @(negedge clk);
    check({tag, " done_pulse_end"}, done, 0);
    prev_diff = ed;
    prev_bout = eb;
  endtask

  initial begin
    int n;
    logic saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    op = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset bout", bout, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("5-3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("3-5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("01-80", 8'h01, 8'h80, 8'h81, 1'b1, 1'b1);

    // Start held high through a run with operands changing every cycle.
    a = 8'h20;
    b = 8'h10;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
    end while (!done && n < 20);
    check("b2b first_latency", n, 9);
    check("b2b first_diff", diff, 8'h10);
    check("b2b first_bout", bout, 0);
    a = 8'h09;
    b = 8'h0C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("b2b second_busy", busy, 1);
      end
    end while (!done && n < 20);
    check("b2b done_spacing", n, 9);
    check("b2b second_diff", diff, 8'hFD);
    check("b2b second_bout", bout, 1);
    check("b2b second_ovf", ovf, 0);
    @(negedge clk);

    // Reset in the middle of 7 - 2.
    a = 8'h07;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst diff", diff, 0);
    check("midrst bout", bout, 0);
    check("midrst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst no_done", saw_done, 0);
    prev_diff = 8'h00;
    prev_bout = 1'b0;
    run_op("9-4", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    op = 1'b0;
    run_op("add 7F+01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("add FF+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op = 1'b1;
    run_op("sub after add", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
